// File: rtl/gb_ext_bus_master_if.sv
// rtl/gb_ext_bus_master_if.sv - command/response stream and split tristate cartridge bus pins
interface gb_ext_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_adr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] adr_out;
  logic        adr_oe;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        n_read_out;
  logic        n_write_out;
  logic        n_rw_oe;
  logic        n_dmadrv;

  modport master (
    input  cmd_valid, cmd_write, cmd_adr, cmd_data, data_in, n_dmadrv,
    output cmd_ready, rsp_valid, rsp_data, adr_out, adr_oe, data_out, data_oe,
           n_read_out, n_write_out, n_rw_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_adr, cmd_data, data_in, n_dmadrv,
    input  cmd_ready, rsp_valid, rsp_data, adr_out, adr_oe, data_out, data_oe,
           n_read_out, n_write_out, n_rw_oe
  );
endinterface

// File: rtl/gb_ext_bus_master.sv
// rtl/gb_ext_bus_master.sv - Game Boy cartridge bus initiator with DMA back-off
// Optional IRQ edge capture is built when GB_BUS_MASTER_IRQ_EN is defined.
module gb_ext_bus_master #(
  parameter int CYCLE_CLKS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  gb_ext_bus_master_if.master        bus,
  input  logic                       n_irq_vb,
  input  logic                       n_irq_st,
  input  logic [1:0]                 irq_ack,
  output logic [1:0]                 irq_pend
);
  localparam logic [3:0] LAST_PHASE = 4'(CYCLE_CLKS - 1);
  localparam logic [3:0] STROBE_END = 4'(CYCLE_CLKS - 2);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic        write_q, write_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  data_q, data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        adr_oe_q, data_oe_q, n_rw_oe_q, n_read_q, n_write_q;
  logic        last, accept, run_d, strobe_d;

  assign last          = (state_q == RUN) && (phase_q == LAST_PHASE);
  assign bus.cmd_ready = !reset && bus.n_dmadrv && ((state_q == IDLE) || last);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    write_d     = write_q;
    adr_d       = adr_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          phase_d = 4'd0;
          write_d = bus.cmd_write;
          adr_d   = bus.cmd_adr;
          data_d  = bus.cmd_data;
        end
      end
      RUN: begin
        if (!bus.n_dmadrv) begin
          state_d = HOLD;
          phase_d = 4'd0;
        end else if (phase_q == LAST_PHASE) begin
          rsp_valid_d = 1'b1;
          if (!write_q) rsp_data_d = bus.data_in;
          phase_d = 4'd0;
          if (accept) begin
            write_d = bus.cmd_write;
            adr_d   = bus.cmd_adr;
            data_d  = bus.cmd_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      HOLD: begin
        // latched command is kept and rerun from phase 0 once the responder lets go
        if (bus.n_dmadrv) begin
          state_d = RUN;
          phase_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d    = (state_d == RUN);
    strobe_d = run_d && (phase_d != 4'd0) && (phase_d <= STROBE_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      write_q     <= 1'b0;
      adr_q       <= 16'h0000;
      data_q      <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'hff;
      adr_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      n_rw_oe_q   <= 1'b0;
      n_read_q    <= 1'b1;
      n_write_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      write_q     <= write_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      adr_oe_q    <= run_d;
      data_oe_q   <= run_d && write_d;
      n_rw_oe_q   <= run_d;
      n_read_q    <= !(strobe_d && !write_d);
      n_write_q   <= !(strobe_d && write_d);
    end
  end

  // enables drop in the very clock the responder claims the bus for DMA
  assign bus.adr_oe      = adr_oe_q && bus.n_dmadrv;
  assign bus.data_oe     = data_oe_q && bus.n_dmadrv;
  assign bus.n_rw_oe     = n_rw_oe_q && bus.n_dmadrv;
  assign bus.adr_out     = adr_q;
  assign bus.data_out    = data_q;
  assign bus.n_read_out  = n_read_q;
  assign bus.n_write_out = n_write_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;

`ifdef GB_BUS_MASTER_IRQ_EN
  logic [1:0] irq_prev_q, irq_pend_q, irq_fall;

  assign irq_fall = irq_prev_q & ~{n_irq_st, n_irq_vb};

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= 2'b11;
      irq_pend_q <= 2'b00;
    end else begin
      irq_prev_q <= {n_irq_st, n_irq_vb};
      irq_pend_q <= irq_fall | (irq_pend_q & ~irq_ack);
    end
  end

  assign irq_pend = irq_pend_q;
`else
  logic unused_irq;
  assign unused_irq = ^{n_irq_vb, n_irq_st, irq_ack};
  assign irq_pend   = 2'b00;
`endif
endmodule

// File: tb/tb_gb_ext_bus_master.sv
// tb/tb_gb_ext_bus_master.sv - randomized bench for gb_ext_bus_master against a phase-rule model
module tb_gb_ext_bus_master;
  localparam int N = 4;
`ifdef GB_BUS_MASTER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       n_irq_vb, n_irq_st;
  logic [1:0] irq_ack, irq_pend;

  gb_ext_bus_master_if bus();

  gb_ext_bus_master #(.CYCLE_CLKS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .n_irq_vb (n_irq_vb),
    .n_irq_st (n_irq_st),
    .irq_ack  (irq_ack),
    .irq_pend (irq_pend)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_rsp;
  logic [1:0]  m_prev, m_pend;
  bit          c_wr  [8];
  logic [15:0] c_adr [8];
  logic [7:0]  c_dat [8];
  logic [7:0]  c_rd  [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input int i);
    bus.cmd_write = c_wr[i];
    bus.cmd_adr   = c_adr[i];
    bus.cmd_data  = c_dat[i];
  endtask

  task automatic check_phase(input string tag, input int i, input int k, input bit exp_rsp);
    bit strobe;
    strobe = (k >= 1) && (k <= N - 2);
    chk({tag, ".adr_oe"},    32'(bus.adr_oe),      32'(1));
    chk({tag, ".adr_out"},   32'(bus.adr_out),     32'(c_adr[i]));
    chk({tag, ".n_rw_oe"},   32'(bus.n_rw_oe),     32'(1));
    chk({tag, ".data_oe"},   32'(bus.data_oe),     32'(c_wr[i]));
    if (c_wr[i]) chk({tag, ".data_out"}, 32'(bus.data_out), 32'(c_dat[i]));
    chk({tag, ".n_read"},    32'(bus.n_read_out),  32'(!(strobe && !c_wr[i])));
    chk({tag, ".n_write"},   32'(bus.n_write_out), 32'(!(strobe && c_wr[i])));
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid),   32'(exp_rsp));
    chk({tag, ".rsp_data"},  32'(bus.rsp_data),    32'(model_rsp));
    chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready),   32'(k == N - 1));
  endtask

  task automatic check_released(input string tag, input bit exp_rsp, input bit exp_ready);
    chk({tag, ".adr_oe"},    32'(bus.adr_oe),    32'(0));
    chk({tag, ".data_oe"},   32'(bus.data_oe),   32'(0));
    chk({tag, ".n_rw_oe"},   32'(bus.n_rw_oe),   32'(0));
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_rsp));
    chk({tag, ".rsp_data"},  32'(bus.rsp_data),  32'(model_rsp));
    chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'(exp_ready));
  endtask

  task automatic check_idle(input string tag, input bit exp_rsp, input bit exp_ready);
    check_released(tag, exp_rsp, exp_ready);
    chk({tag, ".n_read"},  32'(bus.n_read_out),  32'(1));
    chk({tag, ".n_write"}, 32'(bus.n_write_out), 32'(1));
  endtask

  task automatic gen_cmds(input int n, input bit all_reads);
    for (int i = 0; i < n; i++) begin
      c_wr[i]  = all_reads ? 1'b0 : 1'($urandom_range(0, 1));
      c_adr[i] = 16'($urandom);
      c_dat[i] = 8'($urandom);
      c_rd[i]  = 8'($urandom);
    end
  endtask

  // back-to-back commands, cmd_valid held high; starts and ends #1 after a posedge
  task automatic run_core(input string tag, input int n);
    drive_cmd(0);
    bus.cmd_valid = 1'b1;
    bus.data_in   = c_rd[0];
    @(negedge clk);
    chk({tag, ".ready_idle"}, 32'(bus.cmd_ready), 32'(1));
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      bus.data_in = c_rd[i];
      if (i + 1 < n) drive_cmd(i + 1);
      else bus.cmd_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        check_phase(tag, i, k, (k == 0) && (i > 0));
        @(posedge clk); #1;
      end
      if (!c_wr[i]) model_rsp = c_rd[i];
    end
    @(negedge clk);
    check_idle({tag, ".done"}, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle({tag, ".after"}, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic dma_core(input string tag, input int dma_phase, input int len);
    drive_cmd(0);
    bus.cmd_valid = 1'b1;
    bus.data_in   = c_rd[0];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < dma_phase; k++) begin
      @(negedge clk);
      check_phase({tag, ".pre"}, 0, k, 1'b0);
      @(posedge clk); #1;
    end
    bus.n_dmadrv = 1'b0;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      check_released({tag, ".hold"}, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    bus.n_dmadrv = 1'b1;
    @(negedge clk);
    check_idle({tag, ".release"}, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check_phase({tag, ".rerun"}, 0, k, 1'b0);
      @(posedge clk); #1;
    end
    if (!c_wr[0]) model_rsp = c_rd[0];
    @(negedge clk);
    check_idle({tag, ".done"}, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle({tag, ".after"}, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic irq_step(input logic vb, input logic st, input logic [1:0] ack);
    n_irq_vb = vb;
    n_irq_st = st;
    irq_ack  = ack;
    m_pend   = (m_prev & ~{st, vb}) | (m_pend & ~ack);
    m_prev   = {st, vb};
    @(posedge clk); #1;
    chk("irq_pend", 32'(irq_pend), 32'(IRQ_EN ? m_pend : 2'b00));
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_adr   = 16'h0000;
    bus.cmd_data  = 8'h00;
    bus.data_in   = 8'h00;
    bus.n_dmadrv  = 1'b1;
    n_irq_vb      = 1'b1;
    n_irq_st      = 1'b1;
    irq_ack       = 2'b00;
    model_rsp     = 8'hff;
    m_prev        = 2'b11;
    m_pend        = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset", 1'b0, 1'b0);
    chk("reset.adr_out",  32'(bus.adr_out),  32'(16'h0000));
    chk("reset.data_out", 32'(bus.data_out), 32'(8'h00));
    chk("reset.irq_pend", 32'(irq_pend),     32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    c_wr[0] = 1'b0; c_adr[0] = 16'hff40; c_dat[0] = 8'h00; c_rd[0] = 8'h91;
    run_core("rd_ff40", 1);
    chk("rd_ff40.rsp_data", 32'(bus.rsp_data), 32'(8'h91));

    c_wr[0] = 1'b1; c_adr[0] = 16'h8000; c_dat[0] = 8'h5a; c_rd[0] = 8'h33;
    run_core("wr_8000", 1);
    chk("wr_8000.rsp_kept", 32'(bus.rsp_data), 32'(8'h91));

    gen_cmds(3, 1'b1);
    run_core("b2b_reads", 3);

    for (int r = 0; r < 6; r++) begin
      gen_cmds($urandom_range(1, 6), 1'b0);
      run_core("rand_seq", 1);
    end
    for (int r = 0; r < 4; r++) begin
      gen_cmds($urandom_range(2, 6), 1'b0);
      run_core("rand_b2b", $urandom_range(2, 6));
    end

    c_wr[0] = 1'b1; c_adr[0] = 16'hc123; c_dat[0] = 8'ha7; c_rd[0] = 8'h00;
    dma_core("dma_wr", 1, 10);
    for (int r = 0; r < 4; r++) begin
      gen_cmds(1, 1'b0);
      dma_core("dma_rand", $urandom_range(0, N - 1), $urandom_range(1, 12));
    end

    c_wr[0] = 1'b0; c_adr[0] = 16'h4321; c_dat[0] = 8'h00; c_rd[0] = 8'h6e;
    drive_cmd(0);
    bus.cmd_valid = 1'b1;
    bus.data_in   = c_rd[0];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_phase("rst_pre", 0, k, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst.ready_low", 32'(bus.cmd_ready), 32'(0));
    @(posedge clk); #1;
    model_rsp = 8'hff;
    @(negedge clk);
    check_idle("rst.mid", 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst.exit", 1'b0, 1'b1);
    @(posedge clk); #1;

    irq_step(1'b0, 1'b1, 2'b01);
    irq_step(1'b0, 1'b1, 2'b00);
    irq_step(1'b0, 1'b1, 2'b01);
    irq_step(1'b1, 1'b0, 2'b00);
    irq_step(1'b1, 1'b1, 2'b10);
    for (int r = 0; r < 40; r++)
      irq_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
